// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and handshake level constants.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam logic DIV_START     = 1'b1;
    localparam logic DIV_STOP      = 1'b0;
    localparam logic DIV_READY     = 1'b1;
    localparam logic DIV_NOT_READY = 1'b0;

endpackage

// File: rtl/div_iter_param_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_iter_param_if #(
    parameter int WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 busy_o;
    logic                 div_zero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, div_zero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, div_zero_o
    );
endinterface

// File: rtl/div_lzc.sv
// Leading-zero counter (WIDTH -> CNT_W); returns WIDTH for an all-zero input.
// Only instantiated when DIV_EARLY_EXIT_EN is defined.
module div_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] count
);

    // Ascending scan: the highest set bit is the last one to write count.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter_param.sv
// Radix-2 restoring divider, {rem, quo} result; ready after WIDTH+2 edges (2 for /0), held while start_i.
// DIV_EARLY_EXIT_EN skips the dividend's leading zeros; start_i low in DONE releases the result.
module div_iter_param
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    div_iter_param_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e         state, state_nxt;
    logic [WIDTH-1:0]   dvd, dvd_nxt;
    logic [WIDTH-1:0]   rem, rem_nxt;
    logic [WIDTH-1:0]   dsr, dsr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               sign_q, sign_q_nxt;
    logic               sign_r, sign_r_nxt;
    logic               dz, dz_nxt;
    logic [2*WIDTH-1:0] result, result_nxt;
    logic               ready, ready_nxt;
    logic               busy, busy_nxt;
    logic               div_zero, div_zero_nxt;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH-1:0]   start_dvd;
    logic [CNT_W-1:0]   start_cnt;
    logic               start_skip;
    logic               trial_ok;
    logic [WIDTH-1:0]   trial;
    logic [WIDTH-1:0]   q_fix, r_fix;

    assign a_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    assign b_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    assign abs_a = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    assign abs_b = b_neg ? -bus.opdata2_i : bus.opdata2_i;

`ifdef DIV_EARLY_EXIT_EN
    logic [CNT_W-1:0] lz;

    div_lzc #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_lzc (
        .data  (abs_a),
        .count (lz)
    );

    // Leading zeros of |a| only ever produce zero quotient bits, so skip them.
    assign start_dvd  = abs_a << lz;
    assign start_cnt  = lz;
    assign start_skip = (abs_a == '0);
`else
    assign start_dvd  = abs_a;
    assign start_cnt  = '0;
    assign start_skip = 1'b0;
`endif

    // Compare first so the subtraction never needs a borrow bit; the difference fits WIDTH when it is kept.
    assign trial_ok = {rem, dvd[WIDTH-1]} >= {1'b0, dsr};
    assign trial    = {rem[WIDTH-2:0], dvd[WIDTH-1]} - dsr;

    assign q_fix = sign_q ? -dvd : dvd;
    assign r_fix = sign_r ? -rem : rem;

    always_comb begin
        state_nxt    = state;
        dvd_nxt      = dvd;
        rem_nxt      = rem;
        dsr_nxt      = dsr;
        cnt_nxt      = cnt;
        sign_q_nxt   = sign_q;
        sign_r_nxt   = sign_r;
        dz_nxt       = dz;
        result_nxt   = result;
        ready_nxt    = ready;
        busy_nxt     = 1'b0;
        div_zero_nxt = div_zero;

        case (state)
            IDLE: begin
                result_nxt   = '0;
                ready_nxt    = DIV_NOT_READY;
                div_zero_nxt = 1'b0;
                if (bus.start_i == DIV_START && !bus.annul_i) begin
                    sign_q_nxt = a_neg ^ b_neg;
                    sign_r_nxt = a_neg;
                    dsr_nxt    = abs_b;
                    rem_nxt    = '0;
                    if (bus.opdata2_i == '0) begin
                        dz_nxt    = 1'b1;
                        dvd_nxt   = bus.opdata1_i;
                        cnt_nxt   = '0;
                        state_nxt = FIX;
                    end else begin
                        dz_nxt    = 1'b0;
                        dvd_nxt   = start_dvd;
                        cnt_nxt   = start_cnt;
                        state_nxt = start_skip ? FIX : CALC;
                    end
                end
            end

            CALC: begin
                if (bus.annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    busy_nxt = 1'b1;
                    // dvd doubles as the quotient register: dividend bits leave the top, quotient bits enter the bottom.
                    if (trial_ok) begin
                        rem_nxt = trial;
                        dvd_nxt = {dvd[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_nxt = {rem[WIDTH-2:0], dvd[WIDTH-1]};
                        dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
                    end
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_nxt = FIX;
                    end
                end
            end

            FIX: begin
                if (bus.annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    busy_nxt  = 1'b1;
                    state_nxt = DONE;
                    if (dz) begin
                        dvd_nxt = '1;
                        rem_nxt = dvd;
                    end else begin
                        dvd_nxt = q_fix;
                        rem_nxt = r_fix;
                    end
                end
            end

            DONE: begin
                if (bus.start_i == DIV_STOP) begin
                    state_nxt    = IDLE;
                    result_nxt   = '0;
                    ready_nxt    = DIV_NOT_READY;
                    div_zero_nxt = 1'b0;
                end else begin
                    result_nxt   = {rem, dvd};
                    ready_nxt    = DIV_READY;
                    div_zero_nxt = dz;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dvd      <= '0;
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dz       <= 1'b0;
            result   <= '0;
            ready    <= DIV_NOT_READY;
            busy     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state    <= state_nxt;
            dvd      <= dvd_nxt;
            rem      <= rem_nxt;
            dsr      <= dsr_nxt;
            cnt      <= cnt_nxt;
            sign_q   <= sign_q_nxt;
            sign_r   <= sign_r_nxt;
            dz       <= dz_nxt;
            result   <= result_nxt;
            ready    <= ready_nxt;
            busy     <= busy_nxt;
            div_zero <= div_zero_nxt;
        end
    end

    assign bus.result_o   = result;
    assign bus.ready_o    = ready;
    assign bus.busy_o     = busy;
    assign bus.div_zero_o = div_zero;

endmodule

// File: tb/tb_div_iter_param.sv
// Directed table-driven bench for div_iter_param at WIDTH=32 and WIDTH=8, plus annul and async-reset sequences.
module tb_div_iter_param;

    typedef struct {
        int          w;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic        sgn;
    logic        sel8;
    logic [31:0] a_in;
    logic [31:0] b_in;

    int errors = 0;
    int checks = 0;

    div_iter_param_if #(.WIDTH(32)) if32 ();
    div_iter_param_if #(.WIDTH(8))  if8  ();

    assign if32.signed_div_i = sgn;
    assign if32.opdata1_i    = a_in;
    assign if32.opdata2_i    = b_in;
    assign if32.start_i      = start & ~sel8;
    assign if32.annul_i      = annul;
    assign if8.signed_div_i  = sgn;
    assign if8.opdata1_i     = a_in[7:0];
    assign if8.opdata2_i     = b_in[7:0];
    assign if8.start_i       = start & sel8;
    assign if8.annul_i       = annul;

    div_iter_param #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    div_iter_param #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));

    logic [31:0] cur_q, cur_r;
    logic        cur_ready, cur_busy, cur_dz;

    assign cur_q     = sel8 ? {24'h0, if8.result_o[7:0]}  : if32.result_o[31:0];
    assign cur_r     = sel8 ? {24'h0, if8.result_o[15:8]} : if32.result_o[63:32];
    assign cur_ready = sel8 ? if8.ready_o    : if32.ready_o;
    assign cur_busy  = sel8 ? if8.busy_o     : if32.busy_o;
    assign cur_dz    = sel8 ? if8.div_zero_o : if32.div_zero_o;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vec_t vecs [21];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic int exp_lat(input vec_t v);
        logic [31:0] mask;
        logic [31:0] am;
        logic [31:0] bm;
        mask = (v.w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        am   = v.a & mask;
        bm   = v.b & mask;
        if (bm == 32'h0) return 2;
`ifdef DIV_EARLY_EXIT_EN
        begin : early
            logic [31:0] mag;
            int          lz;
            mag = (v.sgn && am[v.w-1]) ? ((~am + 32'd1) & mask) : am;
            if (mag == 32'h0) return 2;
            lz = 0;
            for (int i = v.w - 1; i >= 0 && !mag[i]; i--) lz++;
            return v.w - lz + 2;
        end
`else
        return v.w + 2;
`endif
    endfunction

    task automatic run_op(input int idx, input vec_t v);
        string tag;
        int    lat;
        int    got_lat;
        logic  busy_ok;
        tag = $sformatf("v%0d_w%0d", idx, v.w);
        lat = exp_lat(v);
        @(negedge clk);
        sel8  = (v.w == 8);
        sgn   = v.sgn;
        a_in  = v.a;
        b_in  = v.b;
        start = 1'b1;
        @(posedge clk);
        #1;
        // Operands change right after acceptance and must be ignored.
        a_in    = $urandom;
        b_in    = $urandom;
        sgn     = ~sgn;
        got_lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40 && got_lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (cur_ready === 1'b1) begin
                got_lat = k;
                if (cur_busy !== 1'b0) busy_ok = 1'b0;
            end else if (k < lat && cur_busy !== 1'b1) begin
                busy_ok = 1'b0;
            end
        end
        check({tag, "_lat"},  72'(got_lat), 72'(lat));
        check({tag, "_busy"}, 72'(busy_ok), 72'd1);
        check({tag, "_q"},    72'(cur_q),   72'(v.q));
        check({tag, "_r"},    72'(cur_r),   72'(v.r));
        check({tag, "_dz"},   72'(cur_dz),  72'(v.dz));
        @(negedge clk);
        annul = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_hold"}, {cur_ready, cur_dz, cur_q, cur_r}, {1'b1, v.dz, v.q, v.r});
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_clear"}, {cur_ready, cur_dz, cur_q, cur_r}, 72'd0);
    endtask

    task automatic run_annul(input int w, input logic [31:0] a, input logic [31:0] b, input int at);
        logic seen;
        @(negedge clk);
        sel8  = (w == 8);
        sgn   = 1'b0;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        for (int k = 1; k < at; k++) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        seen = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        for (int k = 0; k < w + 6; k++) begin
            @(posedge clk);
            #1;
            if (cur_ready !== 1'b0 || cur_q !== 32'h0 || cur_r !== 32'h0 || cur_dz !== 1'b0) seen = 1'b1;
        end
        check($sformatf("annul_quiet_w%0d", w), 72'(seen), 72'd0);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        annul = 1'b0;
        sgn   = 1'b0;
        sel8  = 1'b0;
        a_in  = '0;
        b_in  = '0;

        vecs[0]  = '{32, 1'b0, 32'd7,         32'd2,         32'd3,         32'd1,         1'b0};
        vecs[1]  = '{32, 1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0};
        vecs[2]  = '{32, 1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0};
        vecs[3]  = '{32, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0};
        vecs[4]  = '{32, 1'b0, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1};
        vecs[5]  = '{32, 1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0};
        vecs[6]  = '{32, 1'b0, 32'd5,         32'd3,         32'd1,         32'd2,         1'b0};
        vecs[7]  = '{32, 1'b0, 32'd0,         32'd9,         32'd0,         32'd0,         1'b0};
        vecs[8]  = '{32, 1'b1, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1};
        vecs[9]  = '{32, 1'b0, 32'hFFFF_FFFF, 32'd10,        32'h1999_9999, 32'd5,         1'b0};
        vecs[10] = '{32, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
        vecs[11] = '{32, 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0};
        vecs[12] = '{8,  1'b0, 32'h07,        32'h02,        32'h03,        32'h01,        1'b0};
        vecs[13] = '{8,  1'b1, 32'hF9,        32'h02,        32'hFD,        32'hFF,        1'b0};
        vecs[14] = '{8,  1'b1, 32'h07,        32'hFE,        32'hFD,        32'h01,        1'b0};
        vecs[15] = '{8,  1'b1, 32'h80,        32'hFF,        32'h80,        32'h00,        1'b0};
        vecs[16] = '{8,  1'b0, 32'h12,        32'h00,        32'hFF,        32'h12,        1'b1};
        vecs[17] = '{8,  1'b0, 32'h64,        32'h07,        32'h0E,        32'h02,        1'b0};
        vecs[18] = '{8,  1'b0, 32'h05,        32'h03,        32'h01,        32'h02,        1'b0};
        vecs[19] = '{8,  1'b0, 32'h00,        32'h09,        32'h00,        32'h00,        1'b0};
        vecs[20] = '{8,  1'b1, 32'hF0,        32'h03,        32'hFB,        32'hFF,        1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_w32", {if32.ready_o, if32.busy_o, if32.div_zero_o, if32.result_o}, 72'd0);
        check("reset_w8",  {if8.ready_o,  if8.busy_o,  if8.div_zero_o,  if8.result_o},  72'd0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset while a division is in flight clears busy without a clock edge.
        @(negedge clk);
        sel8  = 1'b0;
        a_in  = 32'hF000_0000;
        b_in  = 32'd3;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("busy_calc", 72'(cur_busy), 72'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {cur_busy, cur_ready, cur_q, cur_r}, 72'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) run_op(i, vecs[i]);

        run_annul(32, 32'hF000_0000, 32'd3, 10);
        run_op(100, vecs[5]);
        run_annul(8, 32'hF0, 32'h03, 5);
        run_op(101, vecs[17]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_iter_param.md
Name: div_iter_param

Overview:
- Parametrised iterative radix-2 restoring divider for the MIPS EX stage; next generation of the core's fixed 32-bit divider.
- Handles signed and unsigned DIV/DIVU for any operand width.
- Adds an explicit divide-by-zero flag, a busy indication, a separate sign-fixup state, and optional leading-zero early termination.
- Packs `{remainder, quotient}` into one 2*WIDTH result, consumed by HI/LO writeback.

Parameters:
- WIDTH, 32, operand width in bits (≥ 4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start acceptance.
- opdata1_i  in  WIDTH  dividend.
- opdata2_i  in  WIDTH  divisor.
- start_i  in  1  request; held high until the result is consumed.
- annul_i  in  1  cancel (exception/flush in pipeline).
- result_o  out  2*WIDTH  `{remainder, quotient}`.
- ready_o  out  1  result valid.
- busy_o  out  1  high in CALC/FIX; drives pipeline stall.
- div_zero_o  out  1  valid with ready_o; divisor was zero.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - result_o = 0, ready_o = 0, busy_o = 0, div_zero_o = 0.
  - Internal operand, counter and sign registers = 0.
- Operand and sign-mode capture:
  - All operands and signed_div_i are registered at acceptance.
  - Inputs are ignored afterwards, so later changes to opdata*_i have no effect.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - If start_i=1 and annul_i=0, accept.
  - Latch the magnitudes |a| and |b| (two's-complement negate when signed and MSB=1).
  - Latch sign_q = a_msb ^ b_msb and sign_r = a_msb, both gated by signed.
  - Divisor == 0: set the div-zero flag and go to FIX.
  - Otherwise go to CALC with cnt=0 and partial remainder 0.
  - Outputs while in IDLE: ready_o=0, result_o=0.
- CALC, one bit per cycle:
  - trial = {1'b0, rem[WIDTH-1:0]} shifted left with the next dividend bit, minus {1'b0, |b|}.
  - If trial is non-negative (borrow bit 0), the remainder takes trial and quotient bit = 1.
  - Otherwise the remainder is shifted and quotient bit = 0.
  - cnt increments each cycle; after WIDTH iterations, go to FIX.
- FIX:
  - Quotient negated if sign_q; remainder negated if sign_r.
  - Divide-by-zero: quotient = all-ones, remainder = raw opdata1 (unsigned image, no fixup).
  - Go to DONE.
- DONE:
  - ready_o=1; result_o and div_zero_o hold stable while start_i=1.
  - On start_i=0: return to IDLE with ready_o=0, result_o=0, div_zero_o=0 in the same edge.
- Latency, counted from the accepting edge E:
  - Normal: ready_o high after edge E+WIDTH+2.
  - Divide-by-zero: ready_o high after edge E+2.
- annul_i:
  - In CALC or FIX, annul_i=1 returns to IDLE next edge; no ready_o, outputs stay 0.
  - In DONE, annul_i is ignored; the result is released only by start_i=0.
- Overflow: signed MIN / -1 gives quotient = MIN (natural wrap), remainder 0, no flag.
- Back-to-back: new start accepted no earlier than one cycle after DONE→IDLE.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- When defined, at acceptance:
  - Compute lz = leading-zero count of |a|.
  - Pre-shift |a| left by lz and start cnt at lz, skipping known-zero quotient bits.
  - |a|==0 (and divisor ≠ 0): go straight to FIX, giving quotient 0 and remainder 0.
  - Normal latency becomes E+(WIDTH-lz)+2.
- When undefined: fixed WIDTH iterations; no LZC logic synthesised.
- Results are bit-identical either way.

Decomposition:
- Shared package div_pkg:
  - State encoding typedef (IDLE/CALC/FIX/DONE).
  - Constants DIV_START/DIV_STOP and DIV_READY/DIV_NOT_READY.
- Sub-module div_lzc (parametrised leading-zero counter, WIDTH→CNT_W), instantiated only under DIV_EARLY_EXIT_EN.

Test Plan:
- WIDTH=32, unsigned 7/2, start held → q=0x00000003, r=0x00000001, ready_o after edge E+34, busy_o high edges E+1..E+33.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) → q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 → q=0xFFFFFFFD, r=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0, div_zero_o=0.
- 0x12345678 / 0 → ready_o after E+2, div_zero_o=1, q=0xFFFFFFFF, r=0x12345678; drop start_i → all outputs 0 next edge.
- annul_i pulsed at E+10 → IDLE, ready_o never asserts, new 100/7 then gives q=14, r=2. Repeat the full suite with WIDTH=8.
- DIV_EARLY_EXIT_EN, 0x00000005/0x00000003 → q=1, r=2, ready_o at E+5 (lz=29); 0/9 → q=0, r=0, ready at E+2.
